cpld_uart_ctrl: RTL and testbench

Synthesizable replacement for the board's CPLD serial controller: the responder side of the rdn/wrn/dataready/tbre/tsre bus the CPU drives on the shared low data byte. Accepts one byte per CPU write strobe and serializes it 8N1 on txd. Deserializes rxd into a one-byte receive holding register that the CPU reads with rdn. Sits in the top level between the CPU's UART port pins and the txd/rxd pads, sharing data byte [7:0] with BaseRAM.

---
 rtl/cpld_uart_pkg.sv | 17 +
 rtl/cpld_uart_baud_gen.sv | 29 ++
 rtl/cpld_uart_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cpld_uart_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpld_uart_pkg.sv
// Shared definitions for the CPLD-replacement UART: FSM encodings, framing constants
// and the baud divider computation.
package cpld_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_TICK   = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Truncating divider from clk to the x16 oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/cpld_uart_baud_gen.sv
// Free-running DIV counter producing a one-cycle x16 oversample tick.
// A synchronous clear realigns the tick phase to a frame start.
module cpld_uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/cpld_uart_ctrl.sv
// CPU-side rdn/wrn UART responder: 8N1 transmitter and receiver on the shared data byte.
// Define CPLD_UART_LOOPBACK_EN to feed the receiver from the internal txd instead of rxd.
module cpld_uart_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] data_io,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd
);

  import cpld_uart_pkg::*;

  if (OVERSAMPLE != cpld_uart_pkg::OVERSAMPLE) begin : g_bad_oversample
    $error("cpld_uart_ctrl: only OVERSAMPLE=16 is supported");
  end

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0] TICK_LAST = 4'(cpld_uart_pkg::OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST  = 4'(MID_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic       wrn_q, rdn_q;
  logic       wr_edge, rd_rise;

  tx_state_t  tx_state;
  logic [7:0] tx_hold, tx_shift;
  logic [3:0] tx_tick;
  logic [2:0] tx_bit;
  logic       tx_baud_tick, tx_bit_end, tx_load;

  rx_state_t  rx_state;
  logic [7:0] rx_hold, rx_shift;
  logic [3:0] rx_tick;
  logic [2:0] rx_bit;
  logic       rx_ferr, rx_in, rx_sync_p0, rx_sync_p1;
  logic       rx_baud_tick, rx_start;

  assign wr_edge = !wrn && wrn_q;
  assign rd_rise = rdn && !rdn_q;

  assign data_io = rdn ? 8'hzz : rx_hold;

`ifdef CPLD_UART_LOOPBACK_EN
  assign rx_in = txd;
`else
  assign rx_in = rxd;
`endif

  assign tx_bit_end = tx_baud_tick && (tx_tick == TICK_LAST);
  // Load from IDLE, or chain straight out of STOP so back-to-back frames have no gap.
  assign tx_load    = !tbre && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_end));
  assign rx_start   = (rx_state == RX_IDLE) && !rx_sync_p1;

  cpld_uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (tx_load),
    .tick (tx_baud_tick)
  );

  cpld_uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (rx_start),
    .tick (rx_baud_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn_q    <= 1'b1;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
      tx_hold  <= '0;
      tx_shift <= '0;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_state <= TX_IDLE;
    end else begin
      wrn_q <= wrn;
      if (wr_edge && tbre) begin
        tx_hold <= data_io;
        tbre    <= 1'b0;
      end
      if (tx_load) begin
        tx_shift <= tx_hold;
        tbre     <= 1'b1;
        tsre     <= 1'b0;
        txd      <= 1'b0;
        tx_tick  <= '0;
        tx_bit   <= '0;
        tx_state <= TX_START;
      end else if (tx_baud_tick && tx_state != TX_IDLE) begin
        tx_tick <= tx_tick + 1'b1;
        if (tx_tick == TICK_LAST) begin
          case (tx_state)
            TX_START: begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_state <= TX_DATA;
            end
            TX_DATA: begin
              if (tx_bit == BIT_LAST) begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                txd      <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + 1'b1;
              end
            end
            default: begin
              tsre     <= 1'b1;
              tx_state <= TX_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_q      <= 1'b1;
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      data_ready <= 1'b0;
      rx_hold    <= '0;
      rx_shift   <= '0;
      rx_tick    <= '0;
      rx_bit     <= '0;
      rx_ferr    <= 1'b0;
      rx_state   <= RX_IDLE;
    end else begin
      rdn_q      <= rdn;
      // synchronizer stage p0 -> p1
      rx_sync_p0 <= rx_in;
      rx_sync_p1 <= rx_sync_p0;
      if (rd_rise) data_ready <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync_p1) begin
            rx_tick  <= '0;
            rx_ferr  <= 1'b0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud_tick) begin
            if (rx_tick == MID_LAST) begin
              rx_tick  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (rx_baud_tick) begin
            rx_tick <= rx_tick + 1'b1;
            if (rx_tick == TICK_LAST) begin
              rx_shift <= {rx_sync_p1, rx_shift[7:1]};
              if (rx_bit == BIT_LAST) rx_state <= RX_STOP;
              else                    rx_bit   <= rx_bit + 1'b1;
            end
          end
        end
        default: begin
          // A framing error parks here until the line returns high.
          if (rx_ferr) begin
            if (rx_sync_p1) begin
              rx_ferr  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_baud_tick) begin
            rx_tick <= rx_tick + 1'b1;
            if (rx_tick == TICK_LAST) begin
              if (rx_sync_p1) begin
                rx_hold    <= rx_shift;
                data_ready <= 1'b1;
                rx_state   <= RX_IDLE;
              end else begin
                rx_ferr <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// Directed bench for cpld_uart_ctrl at default parameters (432 clk per bit).
module tb_cpld_uart_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic       data_ready, tbre, tsre, txd;
  wire  [7:0] data_io;
  logic [7:0] data_drv = 8'h00;
  logic       drv_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  assign data_io = drv_en ? data_drv : 8'hzz;

  always #5 clk = ~clk;

  cpld_uart_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data_io    (data_io),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .txd        (txd),
    .rxd        (rxd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] v);
    @(negedge clk);
    data_drv = v;
    drv_en   = 1'b1;
    wrn      = 1'b0;
    @(negedge clk);
    wrn    = 1'b1;
    drv_en = 1'b0;
  endtask

  // Samples txd at mid-bit; lead is the distance in cycles to the middle of the start bit.
  task automatic check_frame(input logic [7:0] v, input int lead, input string tag);
    logic [9:0] bits;
    bits = {1'b1, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? lead : 432) @(negedge clk);
      chk($sformatf("%s_bit%0d", tag, i), 32'(txd), 32'(bits[i]));
    end
  endtask

  task automatic send_rx(input logic [7:0] v, input logic stop);
    logic [9:0] bits;
    bits = {stop, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (432) @(negedge clk);
    end
  endtask

  task automatic read_check(input logic [7:0] exp, input string tag);
    @(negedge clk);
    rdn = 1'b0;
    @(negedge clk);
    chk({tag, "_data"}, 32'(data_io), 32'(exp));
    chk({tag, "_dr_held"}, 32'(data_ready), 32'd1);
    rdn = 1'b1;
    @(negedge clk);
    chk({tag, "_dr_clr"}, 32'(data_ready), 32'd0);
  endtask

  initial begin
    logic idle_ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tbre", 32'(tbre), 32'd1);
    chk("rst_tsre", 32'(tsre), 32'd1);
    chk("rst_dr", 32'(data_ready), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tbre !== 1'b1 || tsre !== 1'b1 || data_ready !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_1000", 32'(idle_ok), 32'd1);

`ifdef CPLD_UART_LOOPBACK_EN
    begin
      int n;
      bus_write(8'hC3);
      n = 0;
      while (data_ready !== 1'b1 && n < 20000) begin
        @(negedge clk);
        n++;
      end
      chk("lb_dr", 32'(data_ready), 32'd1);
      read_check(8'hC3, "lb_c3");
      bus_write(8'hA5);
      repeat (1000) @(negedge clk);
      chk("lb_mid_txd", 32'(txd), 32'd0);
      rst = 1'b1;
      #1;
      chk("lb_rst_txd", 32'(txd), 32'd1);
      chk("lb_rst_tbre", 32'(tbre), 32'd1);
      chk("lb_rst_tsre", 32'(tsre), 32'd1);
      chk("lb_rst_dr", 32'(data_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end
`else
    // Single frame 0xA5
    bus_write(8'hA5);
    chk("a5_tbre_low", 32'(tbre), 32'd0);
    @(negedge clk);
    chk("a5_tbre_back", 32'(tbre), 32'd1);
    chk("a5_start_edge", 32'(txd), 32'd0);
    chk("a5_tsre_busy", 32'(tsre), 32'd0);
    check_frame(8'hA5, 216, "a5");
    repeat (215) @(negedge clk);
    chk("a5_tsre_before_end", 32'(tsre), 32'd0);
    @(negedge clk);
    chk("a5_tsre_end", 32'(tsre), 32'd1);
    chk("a5_txd_idle", 32'(txd), 32'd1);

    // Back-to-back 0x55 / 0x0F, third write dropped
    repeat (20) @(negedge clk);
    bus_write(8'h55);
    chk("b2b_tbre0", 32'(tbre), 32'd0);
    @(negedge clk);
    chk("b2b_start", 32'(txd), 32'd0);
    bus_write(8'h0F);
    chk("b2b_second_taken", 32'(tbre), 32'd0);
    bus_write(8'hFF);
    chk("b2b_third_tbre", 32'(tbre), 32'd0);
    check_frame(8'h55, 212, "f55");
    repeat (216) @(negedge clk);
    chk("chain_txd_start", 32'(txd), 32'd0);
    chk("chain_tbre", 32'(tbre), 32'd1);
    chk("chain_tsre", 32'(tsre), 32'd0);
    check_frame(8'h0F, 216, "f0f");
    repeat (216) @(negedge clk);
    chk("chain_tsre_end", 32'(tsre), 32'd1);
    chk("chain_tbre_end", 32'(tbre), 32'd1);
    idle_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) idle_ok = 1'b0;
    end
    chk("third_dropped_idle", 32'(idle_ok), 32'd1);

    // Receive 0x3C
    chk("rx_dr_before", 32'(data_ready), 32'd0);
    send_rx(8'h3C, 1'b1);
    chk("rx3c_dr", 32'(data_ready), 32'd1);
    read_check(8'h3C, "rx3c");
    drv_en   = 1'b1;
    data_drv = 8'hA6;
    @(negedge clk);
    chk("bus_released", 32'(data_io), 32'hA6);
    drv_en = 1'b0;

    // Framing error, then a short glitch, then a good frame
    send_rx(8'h81, 1'b0);
    repeat (432) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("ferr_dr", 32'(data_ready), 32'd0);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_dr", 32'(data_ready), 32'd0);
    send_rx(8'h96, 1'b1);
    chk("rx96_dr", 32'(data_ready), 32'd1);
    read_check(8'h96, "rx96");

    // Reset mid-frame
    bus_write(8'hA5);
    repeat (1000) @(negedge clk);
    chk("mid_txd", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_tbre", 32'(tbre), 32'd1);
    chk("mid_rst_tsre", 32'(tsre), 32'd1);
    chk("mid_rst_dr", 32'(data_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tsre !== 1'b1) idle_ok = 1'b0;
    end
    chk("post_rst_idle", 32'(idle_ok), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
